// File: rtl/vdf_iter_ctrl_if.sv
// Job, squarer and result signals of the VDF iteration controller.
// The controller attaches through the slave modport; the job source/squarer side uses master.
interface vdf_iter_ctrl_if #(
  parameter int MOD_LEN = 1024,
  parameter int CNT_W   = 64
);
  logic               job_valid;
  logic               job_ready;
  logic [MOD_LEN-1:0] job_x;
  logic [CNT_W-1:0]   job_t;
  logic               sq_start;
  logic [MOD_LEN-1:0] sq_in;
  logic [MOD_LEN-1:0] sq_out;
  logic               sq_valid;
  logic               abort;
  logic               res_valid;
  logic               res_ready;
  logic [MOD_LEN-1:0] res_y;
  logic [CNT_W-1:0]   res_count;
  logic               res_timeout;
  logic               busy;

  modport slave (
    input  job_valid, job_x, job_t, sq_out, sq_valid, abort, res_ready,
    output job_ready, sq_start, sq_in, res_valid, res_y, res_count, res_timeout, busy
  );

  modport master (
    output job_valid, job_x, job_t, sq_out, sq_valid, abort, res_ready,
    input  job_ready, sq_start, sq_in, res_valid, res_y, res_count, res_timeout, busy
  );
endinterface

// File: rtl/vdf_iter_ctrl.sv
// Drives one free-running squarer through T iterations of x -> x^2, with a watchdog
// that ends the job early if the squarer stops producing results.
module vdf_iter_ctrl #(
  parameter int MOD_LEN = 1024,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            reset,
  vdf_iter_ctrl_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [MOD_LEN-1:0] x_q;
  logic [CNT_W-1:0]   target_q;
  logic [MOD_LEN-1:0] res_y_q;
  logic [CNT_W-1:0]   res_count_q;
  logic [CNT_W-1:0]   count_inc;
  logic               res_timeout_q;
  logic [WD_W-1:0]    wdog_q;
  logic               first_run_q;

  logic capture_job;
  logic capture_sq;
  logic set_timeout;
  logic wdog_clear;
  logic wdog_inc;

  assign count_inc = res_count_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The first RUN cycle may see a pulse belonging to whatever the squarer was doing
  // before the launch, so that cycle's sq_valid is never counted.
  always_comb begin
    state_d     = state_q;
    capture_job = 1'b0;
    capture_sq  = 1'b0;
    set_timeout = 1'b0;
    wdog_clear  = 1'b0;
    wdog_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          capture_job = 1'b1;
          state_d     = (bus.job_t == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        wdog_clear = 1'b1;
        state_d    = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.sq_valid && !first_run_q) begin
          capture_sq = 1'b1;
          wdog_clear = 1'b1;
          if (count_inc == target_q) begin
            state_d = DONE;
          end
        end else if (wdog_q == WD_LAST) begin
          set_timeout = 1'b1;
          state_d     = DONE;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      target_q      <= '0;
      res_y_q       <= '0;
      res_count_q   <= '0;
      res_timeout_q <= 1'b0;
      wdog_q        <= '0;
      first_run_q   <= 1'b0;
    end else begin
      if (capture_job) begin
        x_q           <= bus.job_x;
        target_q      <= bus.job_t;
        res_y_q       <= bus.job_x;
        res_count_q   <= '0;
        res_timeout_q <= 1'b0;
      end
      if (capture_sq) begin
        res_y_q     <= bus.sq_out;
        res_count_q <= count_inc;
      end
      if (set_timeout) begin
        res_timeout_q <= 1'b1;
      end
      if (wdog_clear) begin
        wdog_q <= '0;
      end else if (wdog_inc) begin
        wdog_q <= wdog_q + WD_W'(1);
      end
      first_run_q <= (state_q == LAUNCH);
    end
  end

  assign bus.job_ready   = (state_q == IDLE);
  assign bus.sq_start    = (state_q == LAUNCH);
  assign bus.sq_in       = x_q;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.res_y       = res_y_q;
  assign bus.res_count   = res_count_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vdf_iter_ctrl.sv
// Directed bench for vdf_iter_ctrl with a behavioural mod-251 squarer of latency 10
// that keeps iterating on its own result after each launch.
module tb_vdf_iter_ctrl;

  localparam int MOD_LEN = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vdf_iter_ctrl_if #(.MOD_LEN(MOD_LEN), .CNT_W(CNT_W)) bus ();

  vdf_iter_ctrl #(.MOD_LEN(MOD_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit sq_active;
  int sq_cnt;
  int sq_val;
  int pulse_num;
  bit silence_after_first;
  bit inject_stale;
  bit stale_pending;
  int start_count;
  int valid_cycles;

  // Squarer model: relaunch on sq_start, then one result every 10 cycles forever.
  always @(negedge clk) begin
    bus.sq_valid = 1'b0;
    if (bus.sq_start) begin
      sq_active     = 1'b1;
      sq_cnt        = 10;
      sq_val        = int'(bus.sq_in);
      pulse_num     = 0;
      stale_pending = inject_stale;
    end else begin
      if (stale_pending) begin
        stale_pending = 1'b0;
        bus.sq_valid  = 1'b1;
        bus.sq_out    = 8'd3;
      end
      if (sq_active) begin
        sq_cnt = sq_cnt - 1;
        if (sq_cnt == 0) begin
          sq_val       = (sq_val * sq_val) % 251;
          pulse_num    = pulse_num + 1;
          bus.sq_out   = 8'(sq_val);
          bus.sq_valid = !(silence_after_first && pulse_num > 1);
          sq_cnt       = 10;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (bus.sq_start) start_count <= start_count + 1;
    if (bus.res_valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic start_job(input logic [7:0] x, input logic [15:0] t);
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_x     = x;
    bus.job_t     = t;
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (!bus.res_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [7:0] exp_y, input logic [15:0] exp_cnt,
                              input logic exp_to);
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid got %b want 1", name, bus.res_valid);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.res_y !== exp_y) begin
      errors++;
      $display("[TB] FAIL %s_y got %0d want %0d", name, bus.res_y, exp_y);
    end
    checks++;
    if (bus.res_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL %s_count got %0d want %0d", name, bus.res_count, exp_cnt);
    end
    checks++;
    if (bus.res_timeout !== exp_to) begin
      errors++;
      $display("[TB] FAIL %s_timeout got %b want %b", name, bus.res_timeout, exp_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.job_ready, bus.sq_start, bus.res_valid, bus.res_timeout, bus.busy} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 10000",
               {bus.job_ready, bus.sq_start, bus.res_valid, bus.res_timeout, bus.busy});
    end
    checks++;
    if (bus.res_count !== 16'd0 || bus.res_y !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got count %0d y %0d want 0 0", bus.res_count, bus.res_y);
    end
  endtask

  task automatic test_basic();
    int lat;
    int s0;
    int v0;
    s0 = start_count;
    v0 = valid_cycles;
    bus.res_ready = 1'b1;
    start_job(8'd3, 16'd3);
    wait_result(200, lat);
    check_result("basic", lat, 31, 8'd35, 16'd3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_release got valid %b ready %b want 0 1", bus.res_valid, bus.job_ready);
    end
    checks++;
    if (start_count - s0 !== 1 || valid_cycles - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL basic_pulses got starts %0d valids %0d want 1 1",
               start_count - s0, valid_cycles - v0);
    end
  endtask

  task automatic test_zero_t();
    int s0;
    s0 = start_count;
    bus.res_ready = 1'b1;
    start_job(8'd7, 16'd0);
    check_result("zero_t", 0, 0, 8'd7, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (start_count !== s0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_t_nostart got starts %0d valid %b want 0 0", start_count - s0, bus.res_valid);
    end
  endtask

  task automatic test_timeout();
    int lat;
    silence_after_first = 1'b1;
    bus.res_ready = 1'b1;
    start_job(8'd3, 16'd5);
    wait_result(300, lat);
    check_result("timeout", lat, 75, 8'd9, 16'd1, 1'b1);
    @(negedge clk);
    silence_after_first = 1'b0;
  endtask

  task automatic test_stale();
    int lat;
    inject_stale = 1'b1;
    bus.res_ready = 1'b1;
    start_job(8'd3, 16'd1);
    wait_result(200, lat);
    check_result("stale", lat, 11, 8'd9, 16'd1, 1'b0);
    @(negedge clk);
    inject_stale = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bus.res_ready = 1'b0;
    start_job(8'd3, 16'd1);
    wait_result(200, lat);
    check_result("hold", lat, 11, 8'd9, 16'd1, 1'b0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_y !== 8'd9 || bus.res_count !== 16'd1 ||
          bus.job_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL hold_stable got %0d unstable cycles want 0", bad);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release got valid %b busy %b want 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.res_ready = 1'b1;
    start_job(8'd5, 16'd2);
    wait_result(200, lat);
    check_result("b2b_first", lat, 21, 8'd123, 16'd2, 1'b0);
    start_job(8'd2, 16'd4);
    wait_result(200, lat);
    check_result("b2b_second", lat, 41, 8'd25, 16'd4, 1'b0);
  endtask

  task automatic run_to_count_two(input string name);
    int n;
    n = 0;
    bus.res_ready = 1'b1;
    start_job(8'd3, 16'd10);
    while (bus.res_count !== 16'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.res_count !== 16'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_reach got count %0d busy %b want 2 1", name, bus.res_count, bus.busy);
    end
  endtask

  task automatic test_abort();
    int v0;
    run_to_count_two("abort");
    v0 = valid_cycles;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle got ready %b busy %b valid %b want 1 0 0",
               bus.job_ready, bus.busy, bus.res_valid);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (valid_cycles !== v0) begin
      errors++;
      $display("[TB] FAIL abort_noresult got %0d valid cycles want 0", valid_cycles - v0);
    end
  endtask

  task automatic test_reset_midjob();
    int v0;
    run_to_count_two("rstmid");
    v0 = valid_cycles;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_count !== 16'd0 || bus.res_y !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_idle got ready %b busy %b valid %b count %0d y %0d want 1 0 0 0 0",
               bus.job_ready, bus.busy, bus.res_valid, bus.res_count, bus.res_y);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (valid_cycles !== v0) begin
      errors++;
      $display("[TB] FAIL rstmid_noresult got %0d valid cycles want 0", valid_cycles - v0);
    end
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    start_count         = 0;
    valid_cycles        = 0;
    sq_active           = 1'b0;
    sq_cnt              = 0;
    sq_val              = 0;
    pulse_num           = 0;
    silence_after_first = 1'b0;
    inject_stale        = 1'b0;
    stale_pending       = 1'b0;
    reset               = 1'b1;
    bus.job_valid       = 1'b0;
    bus.job_x           = '0;
    bus.job_t           = '0;
    bus.sq_out          = '0;
    bus.sq_valid        = 1'b0;
    bus.abort           = 1'b0;
    bus.res_ready       = 1'b0;
    test_reset();
    test_basic();
    test_zero_t();
    test_timeout();
    test_stale();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_midjob();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
